button_event_arbiter: RTL

- Sits between the pushbutton edge-detector outputs and the consumer logic (counter or command decoder).
- Captures single-cycle press pulses from N_REQ buttons into per-button pending flags, so no press is lost when several arrive together.
- Serializes pending presses through a round-robin arbiter into a small event FIFO.
- Presents the FIFO head as a valid/ready event stream carrying the button index.

---
 rtl/button_event_arbiter_if.sv | 35 +++
 rtl/button_event_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/button_event_arbiter_if.sv
// Button event stream bundle: press pulses in, serialized event ids and status out.
// BTN_EVT_DROP_CNT_EN adds the drop_count status field.
interface button_event_arbiter_if #(
    parameter int N_REQ = 7,
    parameter int IDX_W = 3
);
    logic [N_REQ-1:0] req_pulse;
    logic             evt_ready;
    logic             clear_overflow;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_id;
    logic [N_REQ-1:0] pending;
    logic             overflow;
`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0]       drop_count;

    modport slave (
        input  req_pulse, evt_ready, clear_overflow,
        output evt_valid, evt_id, pending, overflow, drop_count
    );
    modport master (
        output req_pulse, evt_ready, clear_overflow,
        input  evt_valid, evt_id, pending, overflow, drop_count
    );
`else
    modport slave (
        input  req_pulse, evt_ready, clear_overflow,
        output evt_valid, evt_id, pending, overflow
    );
    modport master (
        output req_pulse, evt_ready, clear_overflow,
        input  evt_valid, evt_id, pending, overflow
    );
`endif
endinterface

// File: rtl/button_event_arbiter.sv
// Latches button press pulses, round-robin serializes them into a small event FIFO.
// Optional BTN_EVT_DROP_CNT_EN adds a saturating count of coalesced presses.
module button_event_arbiter #(
    parameter int N_REQ      = 7,
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst_b,
    button_event_arbiter_if.slave   bus
);

    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] mem_q [FIFO_DEPTH];
    logic [IDX_W-1:0] mem_d [FIFO_DEPTH];

    logic             full;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   scan_idx;
    logic [N_REQ-1:0] grant_vec;
    logic             push;
    logic             pop;
    logic             coalesce;

    assign full = (count_q == (PTR_W+1)'(FIFO_DEPTH));

    // First pending bit at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
            end
            if (!grant_vld && !full && pending_q[scan_idx[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign grant_vec = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
    assign push      = grant_vld;
    assign pop       = (count_q != '0) && bus.evt_ready;
    // A fresh pulse on the button being granted re-arms it rather than coalescing.
    assign coalesce  = |(bus.req_pulse & pending_q & ~grant_vec);

    always_comb begin
        pending_d  = (pending_q & ~grant_vec) | bus.req_pulse;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (grant_vld) begin
            rr_ptr_d = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (coalesce) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.evt_valid = (count_q != '0);
    assign bus.evt_id    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clear_overflow) begin
            drop_cnt_d = coalesce ? 8'd1 : 8'd0;
        end else if (coalesce && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

endmodule
